// File: rtl/axi_lite_if.sv
// rtl/axi_lite_if.sv - AXI-Lite read-channel bundle used by the instruction fetch port
interface axi_lite_if #(
    parameter int AW = 64,
    parameter int DW = 64
);
    logic          arvalid;
    logic          arready;
    logic [AW-1:0] araddr;
    logic [2:0]    arprot;
    logic          rvalid;
    logic          rready;
    logic [DW-1:0] rdata;
    logic [1:0]    resp;

    modport M (output arvalid, araddr, arprot, rready, input arready, rvalid, rdata, resp);
    modport S (input arvalid, araddr, arprot, rready, output arready, rvalid, rdata, resp);
endinterface

// File: rtl/rv_fetch_unit.sv
// rtl/rv_fetch_unit.sv - credit-checked instruction fetcher with in-order PC queue and instruction buffer
module rv_fetch_unit #(
    parameter int              XLEN      = 64,
    parameter int              I_DLEN    = 64,
    parameter logic [XLEN-1:0] INIT_ADDR = '0,
    parameter int              DEPTH     = 4,
    parameter int              MAX_OUT   = 2
) (
    input  logic            clk,
    input  logic            rstn,
    axi_lite_if.M           im,
    input  logic            fetch_en,
    input  logic            redirect_valid,
    input  logic [XLEN-1:0] redirect_addr,
    output logic            inst_valid,
    input  logic            inst_ready,
    output logic [31:0]     inst_data,
    output logic [XLEN-1:0] inst_pc,
    output logic            inst_fault
);
    localparam int CW = $clog2(MAX_OUT + 1);
    localparam int BW = $clog2(DEPTH + 1);
    localparam int AW = $clog2(DEPTH);
    localparam int QW = (MAX_OUT > 1) ? $clog2(MAX_OUT) : 1;

    logic [XLEN-1:0] pc_q, pc_d, pc_base;
    logic [XLEN-1:0] araddr_q, araddr_d;
    logic            arvalid_q, arvalid_d;
    logic [CW-1:0]   out_q, out_d;
    logic [CW-1:0]   drop_q, drop_d;
    logic            fault_q, fault_d;

    logic [XLEN-1:0] pcq_mem [MAX_OUT];
    logic [QW-1:0]   pcq_rd, pcq_wr;
    logic [XLEN-1:0] pcq_head;

    logic [XLEN-1:0] buf_pc   [DEPTH];
    logic [31:0]     buf_word [DEPTH];
    logic            buf_flt  [DEPTH];
    logic [AW-1:0]   buf_rd, buf_wr;
    logic [BW-1:0]   buf_cnt, buf_cnt_d;

    logic        hs_ar, hs_r, hs_inst, rready;
    logic        misalign, r_keep, r_fault, ar_hold, can_issue;
    logic [31:0] word_sel;

    function automatic logic [QW-1:0] q_inc(input logic [QW-1:0] p);
        return (32'(p) == MAX_OUT - 1) ? '0 : p + QW'(1);
    endfunction

    assign hs_ar    = arvalid_q & im.arready;
    assign rready   = (out_q != '0);
    assign hs_r     = im.rvalid & rready;
    assign hs_inst  = inst_valid & inst_ready;
    assign misalign = redirect_valid & (redirect_addr[1:0] != 2'b00);
    // Responses owed to a flushed stream are the oldest in flight, so drops come first.
    assign r_keep   = hs_r & ~redirect_valid & (drop_q == '0);
    assign r_fault  = (im.resp != 2'b00);
    assign ar_hold  = arvalid_q & ~im.arready;
    assign pcq_head = pcq_mem[pcq_rd];

    if (I_DLEN == 64) begin : g_w64
        assign word_sel = pcq_head[2] ? im.rdata[63:32] : im.rdata[31:0];
    end else begin : g_w32
        assign word_sel = im.rdata[31:0];
    end

    always_comb begin
        out_d     = out_q + CW'(hs_ar) - CW'(hs_r);
        drop_d    = drop_q;
        buf_cnt_d = buf_cnt;
        fault_d   = fault_q;
        if (redirect_valid) begin
            // Everything still in flight, including a held AR, belongs to the old stream.
            drop_d    = out_d + CW'(ar_hold);
            buf_cnt_d = BW'(misalign);
            fault_d   = misalign;
        end else begin
            if (hs_r && (drop_q != '0)) drop_d = drop_q - CW'(1);
            buf_cnt_d = buf_cnt + BW'(r_keep) - BW'(hs_inst);
            fault_d   = fault_q | (r_keep & r_fault);
        end

        pc_base   = redirect_valid ? redirect_addr : pc_q;
        can_issue = fetch_en & ~fault_d & (32'(out_d) < MAX_OUT)
                  & ((32'(out_d) + 32'(buf_cnt_d)) < DEPTH);

        arvalid_d = 1'b1;
        araddr_d  = araddr_q;
        pc_d      = pc_base;
        if (!ar_hold) begin
            arvalid_d = can_issue;
            if (can_issue) begin
                araddr_d = pc_base;
                pc_d     = pc_base + XLEN'(4);
            end
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            pc_q      <= INIT_ADDR;
            araddr_q  <= INIT_ADDR;
            arvalid_q <= 1'b0;
            out_q     <= '0;
            drop_q    <= '0;
            fault_q   <= 1'b0;
            pcq_rd    <= '0;
            pcq_wr    <= '0;
            buf_rd    <= '0;
            buf_wr    <= '0;
            buf_cnt   <= '0;
        end else begin
            pc_q      <= pc_d;
            araddr_q  <= araddr_d;
            arvalid_q <= arvalid_d;
            out_q     <= out_d;
            drop_q    <= drop_d;
            fault_q   <= fault_d;
            buf_cnt   <= buf_cnt_d;
            if (hs_ar) pcq_wr <= q_inc(pcq_wr);
            if (hs_r)  pcq_rd <= q_inc(pcq_rd);
            if (redirect_valid) begin
                buf_rd <= buf_wr;
                if (misalign) buf_wr <= buf_wr + AW'(1);
            end else begin
                if (r_keep)  buf_wr <= buf_wr + AW'(1);
                if (hs_inst) buf_rd <= buf_rd + AW'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (hs_ar) pcq_mem[pcq_wr] <= araddr_q;
        if (misalign) begin
            buf_pc[buf_wr]   <= redirect_addr;
            buf_word[buf_wr] <= '0;
            buf_flt[buf_wr]  <= 1'b1;
        end else if (r_keep) begin
            buf_pc[buf_wr]   <= pcq_head;
            buf_word[buf_wr] <= word_sel;
            buf_flt[buf_wr]  <= r_fault;
        end
    end

    assign inst_valid = (buf_cnt != '0);
    assign inst_data  = inst_valid ? buf_word[buf_rd] : '0;
    assign inst_pc    = inst_valid ? buf_pc[buf_rd] : '0;
    assign inst_fault = inst_valid & buf_flt[buf_rd];

    assign im.arvalid = arvalid_q;
    assign im.araddr  = araddr_q;
    assign im.arprot  = 3'b100;
    assign im.rready  = rready;
endmodule

// File: doc/rv_fetch_unit.md
RV_FETCH_UNIT -- requirements
Module: rv_fetch_unit

Interface
REQ-001 SHALL have parameter XLEN, default 64, meaning core and PC width.
REQ-002 SHALL have parameter I_DLEN, default 64, meaning read-data width; legal values are 32 and 64.
REQ-003 SHALL have parameter INIT_ADDR, default 0, meaning the fetch PC after reset; it SHALL be 4-byte aligned.
REQ-004 SHALL have parameter DEPTH, default 4, meaning instruction-buffer entries; it SHALL be a power of 2 and at least 2.
REQ-005 SHALL have parameter MAX_OUT, default 2, meaning the maximum number of outstanding AR requests; it SHALL be at least 1.
REQ-006 SHALL have port clk, input, 1 bit: the single clock, rising edge.
REQ-007 SHALL have port rstn, input, 1 bit: asynchronous, active-low reset.
REQ-008 SHALL have port im, axi_lite_if.M, read channels only: arvalid, arready, araddr[XLEN-1:0], arprot[2:0], rvalid, rready, rdata[I_DLEN-1:0], resp[1:0].
REQ-009 SHALL have port fetch_en, input, 1 bit: permits new AR issue.
REQ-010 SHALL have port redirect_valid, input, 1 bit: a jump or branch has been taken.
REQ-011 SHALL have port redirect_addr, input, XLEN bits: the new fetch PC.
REQ-012 SHALL have port inst_valid, output, 1 bit: the buffer head is valid.
REQ-013 SHALL have port inst_ready, input, 1 bit: the consumer accepts the buffer head.
REQ-014 SHALL have port inst_data, output, 32 bits: the instruction word.
REQ-015 SHALL have port inst_pc, output, XLEN bits: the PC of inst_data.
REQ-016 SHALL have port inst_fault, output, 1 bit: resp was not OKAY (2'b00), or the redirect target was misaligned.

Function
REQ-017 SHALL drive arprot as the constant 3'b100.
REQ-018 SHALL assert arvalid when all of the following hold: fetch_en=1, no fault is latched, outstanding < MAX_OUT, and outstanding + buffered < DEPTH (credit check).
REQ-019 SHALL keep arvalid and araddr stable while arvalid=1 and arready=0, regardless of fetch_en or redirect_valid.
REQ-020 SHALL, on an AR handshake, push araddr into an in-order PC queue of MAX_OUT entries and advance the fetch PC by 4, wrapping modulo 2^XLEN.
REQ-021 SHALL issue back-to-back AR requests at one per cycle when arready=1 and credit is available.
REQ-022 SHALL hold rready=1 whenever outstanding > 0; buffer space is reserved by the credit check, so no response is ever refused.
REQ-023 SHALL, on an R handshake, pop the PC queue and write the entry {pc, word, fault} to the buffer tail; the write is visible on inst_* no earlier than the next cycle (minimum latency from R handshake to inst_valid is 1 cycle).
REQ-024 SHALL, when I_DLEN=64, select word = rdata[63:32] if pc[2]=1 and rdata[31:0] otherwise; when I_DLEN=32, word = rdata[31:0].
REQ-025 SHALL treat any resp other than 2'b00 as a fault: the entry gets fault=1, fault is latched, and AR issue stops until redirect_valid.
REQ-026 SHALL present the buffer head on inst_data, inst_pc and inst_fault whenever inst_valid=1, and pop the head on inst_valid & inst_ready.
REQ-027 SHALL allow a buffer push and pop in the same cycle when the buffer is full; a full buffer blocks only new AR issue through the credit check.
REQ-028 SHALL, on redirect_valid, perform all of the following: flush the buffer (inst_valid=0 next cycle), clear the latched fault, load the fetch PC with redirect_addr, and mark every currently outstanding request (including a pending, unaccepted AR) for discard.
REQ-029 SHALL consume discarded responses with rready=1 and never write them to the buffer, using a drop counter of width clog2(MAX_OUT+1).
REQ-030 SHALL issue the first AR at redirect_addr at the earliest in the cycle after redirect_valid, or once the pending AR has handshaken if one is pending.
REQ-031 SHALL let redirect_valid win over a same-cycle R handshake: that response is dropped.
REQ-032 SHALL let redirect_valid together with an inst handshake in the same cycle count as a valid consume, after which the buffer is flushed.
REQ-033 SHALL, when redirect_addr[1:0] != 0, issue no AR and place one entry {redirect_addr, 0, fault=1} in the buffer next cycle, then halt AR issue until the next redirect_valid.
REQ-034 SHALL, when redirect_valid arrives while drops are still pending, add the new outstanding count to the drop counter.

Reset
REQ-035 SHALL, on rstn=0 and asynchronously, set arvalid=0, rready=0, araddr=INIT_ADDR, inst_valid=0, inst_data=0, inst_pc=0, inst_fault=0, clear all buffer, PC-queue, credit, drop and fault state, and set the fetch PC to INIT_ADDR.
REQ-036 SHALL, on rstn asserted mid-transaction, leave no outstanding or drop state after reset release; the bench SHALL re-initialise the slave alongside the core.
REQ-037 SHALL allow the first AR to be issued at INIT_ADDR no earlier than the first rising edge after rstn deasserts with fetch_en=1.

Verification
REQ-038 Streaming: INIT_ADDR=0x1000, arready=rvalid=1, inst_ready=1 -> inst_pc = 0x1000, 0x1004, 0x1008, ...; with I_DLEN=64, words alternate rdata[31:0] and rdata[63:32].
REQ-039 Backpressure: inst_ready=0 for 20 cycles with DEPTH=4 -> exactly 4 entries buffered, no 5th AR issued, and araddr held stable while arready=0.
REQ-040 Redirect with 2 outstanding: redirect_addr=0x2000 -> both old responses dropped, and the next inst_pc is 0x2000 with no stale entry.
REQ-041 Fault: resp=2'b10 at 0x1008 -> entry at 0x1008 has inst_fault=1 and no further AR; redirect to 0x3000 -> fetch resumes at 0x3000.
REQ-042 Misaligned redirect to 0x2002 -> one entry with inst_pc=0x2002 and inst_fault=1, and no AR issued.
REQ-043 Asynchronous reset pulse mid-burst -> all outputs at their reset values immediately, then fetch restarts at INIT_ADDR.
